// File: rtl/multi_channel_scoreboard_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : multi_channel_scoreboard_if
// Brief    : Observation bus between a shared multi-channel FIFO harness and
//            its scoreboard: the FIFO push/pop/select/data signals plus the
//            per-channel arm requests and the scoreboard status outputs.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface multi_channel_scoreboard_if #(
   parameter int WIDTH     = 8,
   parameter int NUM_FIFOS = 2,
   parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
);
   // Harness-side signals observed by the scoreboard
   logic [NUM_FIFOS-1:0] start;
   logic                 push;
   logic                 pop;
   logic [SEL_WIDTH-1:0] push_sel;
   logic [SEL_WIDTH-1:0] pop_sel;
   logic [WIDTH-1:0]     data_in;
   logic [WIDTH-1:0]     data_out;

   // Scoreboard status
   logic                 prop_signal;
   logic [NUM_FIFOS-1:0] fail;
   logic [NUM_FIFOS-1:0] done;
   logic                 proto_err;

   modport master (
      output start, push, pop, push_sel, pop_sel, data_in, data_out,
      input  prop_signal, fail, done, proto_err
   );

   modport slave (
      input  start, push, pop, push_sel, pop_sel, data_in, data_out,
      output prop_signal, fail, done, proto_err
   );
endinterface
`default_nettype wire

// File: rtl/multi_channel_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : multi_channel_scoreboard
// Brief    : Tracks one marked word per logical channel of a shared FIFO and
//            checks that it leaves the FIFO in order with the captured value.
//            Per channel: occupancy counter, IDLE/WAIT/TRACK/DONE tracker,
//            entries-ahead counter and captured word. Aggregates a sticky
//            protocol-error flag and a "no channel failed" property output.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module multi_channel_scoreboard #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int NUM_FIFOS = 2,
   parameter int REARM     = 0,
   parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
   parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   multi_channel_scoreboard_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_TRACK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] C_DEPTH = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] C_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] C_ZERO  = '0;

   logic [NUM_FIFOS-1:0] perr_vec;
   logic [NUM_FIFOS-1:0] fail_vec;
   logic [NUM_FIFOS-1:0] done_vec;
   logic                 proto_err_q;
   logic                 proto_err_d;

   for (genvar c = 0; c < NUM_FIFOS; c++) begin : g_chan
      logic                 push_c;
      logic                 pop_c;
      logic                 perr_c;
      logic                 capture;
      logic [CNT_WIDTH-1:0] occ_q, occ_d;
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0]     cap_q, cap_d;
      logic                 fail_q, fail_d;
      state_t               state_q, state_d;

      assign push_c = bus.push && (bus.pop_sel == bus.pop_sel) && (bus.push_sel == SEL_WIDTH'(c));
      assign pop_c  = bus.pop  && (bus.pop_sel  == SEL_WIDTH'(c));

      // Occupancy tracking; illegal pops/pushes flag an error and leave occ alone
      always_comb begin
         occ_d  = occ_q;
         perr_c = 1'b0;
         if (pop_c && (occ_q == C_ZERO)) begin
            perr_c = 1'b1;
         end else if (push_c && !pop_c && (occ_q == C_DEPTH)) begin
            perr_c = 1'b1;
         end else if (push_c && !pop_c) begin
            occ_d = occ_q + C_ONE;
         end else if (pop_c && !push_c) begin
            occ_d = occ_q - C_ONE;
         end
      end

      // Tracker next state: arm, capture the marked word, count down, compare
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         cap_d   = cap_q;
         fail_d  = fail_q;
         capture = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start[c]) begin
                  if (push_c) begin
                     capture = 1'b1;
                  end else begin
                     state_d = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (push_c) begin
                  capture = 1'b1;
               end
            end
            ST_TRACK: begin
               if (pop_c) begin
                  if (cnt_q != C_ZERO) begin
                     cnt_d = cnt_q - C_ONE;
                  end else begin
                     if (bus.data_out != cap_q) begin
                        fail_d = 1'b1;
                     end
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (REARM != 0) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
         // A pop in the capture cycle removes an older entry, so it shortens
         // the distance; a pop on an empty channel is an error and is ignored.
         if (capture) begin
            cap_d   = bus.data_in;
            cnt_d   = (pop_c && (occ_q != C_ZERO)) ? (occ_q - C_ONE) : occ_q;
            state_d = ST_TRACK;
         end
      end

      // Per-channel state registers
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            occ_q   <= C_ZERO;
            cnt_q   <= C_ZERO;
            cap_q   <= '0;
            fail_q  <= 1'b0;
            state_q <= ST_IDLE;
         end else begin
            occ_q   <= occ_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            fail_q  <= fail_d;
            state_q <= state_d;
         end
      end

      assign perr_vec[c] = perr_c;
      assign fail_vec[c] = fail_q;
      assign done_vec[c] = (state_q == ST_DONE);
   end

   // Sticky protocol error across all channels
   always_comb begin
      proto_err_d = proto_err_q | (|perr_vec);
   end

   // Protocol error register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= proto_err_d;
      end
   end

   assign bus.fail        = fail_vec;
   assign bus.done        = done_vec;
   assign bus.proto_err   = proto_err_q;
   assign bus.prop_signal = ~|fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_multi_channel_scoreboard
// Brief    : Bench for multi_channel_scoreboard. Two instances (REARM=0 and
//            REARM=1) watch the same stimulus. A queue-based FIFO model with
//            per-entry marks predicts done/fail/proto_err for both.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_multi_channel_scoreboard;

   localparam int M_IDLE  = 0;
   localparam int M_WAIT  = 1;
   localparam int M_TRACK = 2;
   localparam int M_DONE  = 3;

   typedef struct packed {
      logic [1:0] mark;   // bit k: marked word of instance k
      logic [7:0] data;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] start = '0;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic       push_sel = 1'b0;
   logic       pop_sel = 1'b0;
   logic [7:0] data_in = '0;
   logic [7:0] data_out = '0;

   int checks = 0;
   int errors = 0;

   // Behavioural model
   ent_t       q[2][$];
   int         m_st[2][2];
   logic [1:0] m_fail[2];
   logic       m_perr;

   always #5 clk = ~clk;

   multi_channel_scoreboard_if #(.WIDTH(8), .NUM_FIFOS(2)) bus0 ();
   multi_channel_scoreboard_if #(.WIDTH(8), .NUM_FIFOS(2)) bus1 ();

   assign bus0.start = start;   assign bus1.start = start;
   assign bus0.push = push;     assign bus1.push = push;
   assign bus0.pop = pop;       assign bus1.pop = pop;
   assign bus0.push_sel = push_sel; assign bus1.push_sel = push_sel;
   assign bus0.pop_sel = pop_sel;   assign bus1.pop_sel = pop_sel;
   assign bus0.data_in = data_in;   assign bus1.data_in = data_in;
   assign bus0.data_out = data_out; assign bus1.data_out = data_out;

   multi_channel_scoreboard #(.WIDTH(8), .DEPTH(4), .NUM_FIFOS(2), .REARM(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0));
   multi_channel_scoreboard #(.WIDTH(8), .DEPTH(4), .NUM_FIFOS(2), .REARM(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1));

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: shared FIFO contents, marks and per-instance tracker state
   always @(posedge clk or posedge rst) begin
      logic       pc, uc;
      logic [1:0] hit, newmark;
      ent_t       fr;
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            q[c].delete();
            m_st[0][c] = M_IDLE;
            m_st[1][c] = M_IDLE;
         end
         m_fail[0] = '0;
         m_fail[1] = '0;
         m_perr = 1'b0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            pc = pop && (int'(pop_sel) == c);
            uc = push && (int'(push_sel) == c);
            hit = '0;
            newmark = '0;
            if (pc) begin
               if (q[c].size() == 0) begin
                  m_perr = 1'b1;
               end else begin
                  fr = q[c].pop_front();
                  for (int k = 0; k < 2; k++) begin
                     if (fr.mark[k]) begin
                        hit[k] = 1'b1;
                        if (data_out != fr.data) m_fail[k][c] = 1'b1;
                     end
                  end
               end
            end
            for (int k = 0; k < 2; k++) begin
               case (m_st[k][c])
                  M_DONE:  if (k == 1) m_st[k][c] = M_IDLE;
                  M_TRACK: if (hit[k]) m_st[k][c] = M_DONE;
                  M_IDLE: begin
                     if (start[c]) begin
                        if (uc) begin
                           m_st[k][c] = M_TRACK;
                           newmark[k] = 1'b1;
                        end else begin
                           m_st[k][c] = M_WAIT;
                        end
                     end
                  end
                  default: begin
                     if (uc) begin
                        m_st[k][c] = M_TRACK;
                        newmark[k] = 1'b1;
                     end
                  end
               endcase
            end
            if (uc) begin
               if (q[c].size() < 4) q[c].push_back({newmark, data_in});
               else m_perr = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      logic [1:0] ed0, ed1;
      if (!rst) begin
         for (int c = 0; c < 2; c++) begin
            ed0[c] = (m_st[0][c] == M_DONE);
            ed1[c] = (m_st[1][c] == M_DONE);
         end
         check("cmp_done_r0", {6'd0, bus0.done}, {6'd0, ed0});
         check("cmp_done_r1", {6'd0, bus1.done}, {6'd0, ed1});
         check("cmp_fail_r0", {6'd0, bus0.fail}, {6'd0, m_fail[0]});
         check("cmp_fail_r1", {6'd0, bus1.fail}, {6'd0, m_fail[1]});
         check("cmp_prop_r0", {7'd0, bus0.prop_signal}, {7'd0, ~|m_fail[0]});
         check("cmp_prop_r1", {7'd0, bus1.prop_signal}, {7'd0, ~|m_fail[1]});
         check("cmp_perr_r0", {7'd0, bus0.proto_err}, {7'd0, m_perr});
         check("cmp_perr_r1", {7'd0, bus1.proto_err}, {7'd0, m_perr});
      end
   end

   // Apply one cycle of stimulus; data_out comes from the FIFO model head
   task automatic drive(input logic [1:0] st, input logic pu, input int ps, input logic [7:0] di,
                        input logic po, input int qs, input logic [7:0] corrupt);
      start    = st;
      push     = pu;
      push_sel = ps[0];
      data_in  = di;
      pop      = po;
      pop_sel  = qs[0];
      data_out = (po && q[qs].size() > 0) ? (q[qs][0].data ^ corrupt) : 8'h00;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      drive(2'b00, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00);
   endtask

   task automatic do_reset();
      start = '0; push = 1'b0; pop = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      #2;
      check("rst_done", {6'd0, bus0.done}, 8'h00);
      check("rst_fail", {6'd0, bus0.fail}, 8'h00);
      check("rst_prop", {7'd0, bus0.prop_signal}, 8'h01);
      check("rst_perr", {7'd0, bus0.proto_err}, 8'h00);
      rst = 1'b0;

      // Minimum latency check on channel 0
      drive(2'b01, 1'b1, 0, 8'hA5, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 0, 8'h00);
      check("t1_done_r0", {6'd0, bus0.done}, 8'h01);
      check("t1_fail_r0", {6'd0, bus0.fail}, 8'h00);
      check("t1_prop_r0", {7'd0, bus0.prop_signal}, 8'h01);
      check("t1_done_r1", {6'd0, bus1.done}, 8'h01);
      idle();
      check("t1_hold_r0", {6'd0, bus0.done}, 8'h01);
      check("t1_pulse_r1", {6'd0, bus1.done}, 8'h00);

      // Channel 1 tracked word behind two entries, returned wrong
      do_reset();
      drive(2'b00, 1'b1, 1, 8'h11, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b1, 1, 8'h22, 1'b0, 0, 8'h00);
      drive(2'b10, 1'b1, 1, 8'h33, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 1, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 1, 8'h00);
      check("t2_nodone", {6'd0, bus0.done}, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 1, 8'h33 ^ 8'h44);
      check("t2_fail_r0", {6'd0, bus0.fail}, 8'h02);
      check("t2_prop_r0", {7'd0, bus0.prop_signal}, 8'h00);
      check("t2_done_r0", {6'd0, bus0.done}, 8'h02);
      check("t2_fail_r1", {6'd0, bus1.fail}, 8'h02);

      // Interleaved channels, ch1 pop alongside a ch0 push
      do_reset();
      drive(2'b00, 1'b1, 0, 8'h01, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b1, 1, 8'h02, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b1, 1, 8'h03, 1'b0, 0, 8'h00);
      drive(2'b11, 1'b1, 0, 8'h5A, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b1, 1, 8'hC3, 1'b1, 0, 8'h00);
      drive(2'b00, 1'b1, 0, 8'h77, 1'b1, 1, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 0, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 1, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 1, 8'h00);
      check("t3_done_r0", {6'd0, bus0.done}, 8'h03);
      check("t3_fail_r0", {6'd0, bus0.fail}, 8'h00);
      check("t3_done_r1", {6'd0, bus1.done}, 8'h02);

      // Capture with a simultaneous pop in WAIT at occ=2
      do_reset();
      drive(2'b00, 1'b1, 0, 8'h10, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b1, 0, 8'h20, 1'b0, 0, 8'h00);
      drive(2'b01, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b1, 0, 8'hAB, 1'b1, 0, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 0, 8'hFF);
      check("t4_skip_done", {6'd0, bus0.done}, 8'h00);
      check("t4_skip_fail", {6'd0, bus0.fail}, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 0, 8'h00);
      check("t4_done", {6'd0, bus0.done}, 8'h01);
      check("t4_fail", {6'd0, bus0.fail}, 8'h00);

      // Pop on empty, then reset asserted mid-TRACK
      do_reset();
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 0, 8'h00);
      check("t5_perr", {7'd0, bus0.proto_err}, 8'h01);
      idle();
      check("t5_perr_sticky", {7'd0, bus1.proto_err}, 8'h01);
      drive(2'b01, 1'b1, 0, 8'h99, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 0, 8'h01);
      check("t5_fail_set", {6'd0, bus0.fail}, 8'h01);
      drive(2'b10, 1'b1, 1, 8'h55, 1'b0, 0, 8'h00);
      rst = 1'b1;
      #1;
      check("t5_rst_perr", {7'd0, bus0.proto_err}, 8'h00);
      check("t5_rst_fail", {6'd0, bus0.fail}, 8'h00);
      check("t5_rst_done", {6'd0, bus0.done}, 8'h00);
      check("t5_rst_prop", {7'd0, bus0.prop_signal}, 8'h01);
      start = '0; push = 1'b0; pop = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Rearm: two checks on channel 0, second one wrong
      do_reset();
      drive(2'b01, 1'b1, 0, 8'h11, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 0, 8'h00);
      check("t6_done1_r1", {6'd0, bus1.done}, 8'h01);
      check("t6_fail1_r1", {6'd0, bus1.fail}, 8'h00);
      idle();
      check("t6_gap_r1", {6'd0, bus1.done}, 8'h00);
      drive(2'b01, 1'b1, 0, 8'h22, 1'b0, 0, 8'h00);
      drive(2'b00, 1'b0, 0, 8'h00, 1'b1, 0, 8'h01);
      check("t6_done2_r1", {6'd0, bus1.done}, 8'h01);
      check("t6_fail2_r1", {6'd0, bus1.fail}, 8'h01);
      check("t6_prop_r1", {7'd0, bus1.prop_signal}, 8'h00);
      check("t6_fail_r0", {6'd0, bus0.fail}, 8'h00);
      check("t6_done_r0", {6'd0, bus0.done}, 8'h01);

      // Randomized legal traffic against the model
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int i = 0; i < 250; i++) begin
            logic [1:0] st;
            logic       pu, po;
            int         ps, qs;
            logic [7:0] cr;
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            pu = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            ps = int'($urandom_range(0, 1));
            qs = int'($urandom_range(0, 1));
            if (po && q[qs].size() == 0) po = 1'b0;
            if (pu && !(q[ps].size() < 4 || (po && qs == ps))) pu = 1'b0;
            cr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            drive(st, pu, ps, 8'($urandom_range(0, 255)), po, qs, cr);
         end
      end

      idle();
      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
